// File: rtl/decoder_scan_seq_if.sv
// decoder_scan_seq_if
//   Handshake / decode bus for decoder_scan_seq.
//   master : drives enable, mode, sel, sel_valid, dwell (and thermo when
//            DECODER_THERMO_EN is defined); observes the decoder outputs.
//   slave  : the decoder itself.
//   Signals:
//     enable     0 forces the decoder idle, all lines low
//     mode       0 = DIRECT (handshaked select), 1 = SCAN (self-stepping)
//     sel        DIRECT select index
//     sel_valid  sel presented
//     sel_ready  decoder can accept sel this cycle
//     dwell      SCAN hold per line, in cycles minus one
//     out        decoded lines (registered)
//     out_idx    index currently driven
//     out_valid  out holds a legal decode
//     scan_wrap  1-cycle pulse when SCAN wraps to line 0
//     sel_err    1-cycle pulse after an out-of-range sel was accepted
//     thermo     (DECODER_THERMO_EN only) thermometer instead of one-hot
interface decoder_scan_seq_if #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 2**SEL_W,
    parameter int DWELL_W = 8
);
    logic                enable;
    logic                mode;
    logic [SEL_W-1:0]    sel;
    logic                sel_valid;
    logic                sel_ready;
    logic [DWELL_W-1:0]  dwell;
    logic [NUM_OUT-1:0]  out;
    logic [SEL_W-1:0]    out_idx;
    logic                out_valid;
    logic                scan_wrap;
    logic                sel_err;
`ifdef DECODER_THERMO_EN
    logic                thermo;

    modport master (
        output enable, mode, sel, sel_valid, dwell, thermo,
        input  sel_ready, out, out_idx, out_valid, scan_wrap, sel_err
    );
    modport slave (
        input  enable, mode, sel, sel_valid, dwell, thermo,
        output sel_ready, out, out_idx, out_valid, scan_wrap, sel_err
    );
`else
    modport master (
        output enable, mode, sel, sel_valid, dwell,
        input  sel_ready, out, out_idx, out_valid, scan_wrap, sel_err
    );
    modport slave (
        input  enable, mode, sel, sel_valid, dwell,
        output sel_ready, out, out_idx, out_valid, scan_wrap, sel_err
    );
`endif
endinterface

// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq
//   Registered SEL_W-to-NUM_OUT line decoder with enable and two modes:
//   DIRECT decodes a select taken over a valid/ready handshake, SCAN steps a
//   single active line through 0..NUM_OUT-1 holding each for dwell+1 cycles.
//   Ports:
//     clk  clock, all state on rising edge
//     rst  asynchronous active-high reset
//     io   decoder_scan_seq_if.slave (see interface file for signal list)
//   Build option:
//     DECODER_THERMO_EN  adds io.thermo; when 1 at decode time, out lights
//                        lines [out_idx:0] instead of a single line.
//   Params: SEL_W (index width), NUM_OUT (2..2**SEL_W lines), DWELL_W.

// One output line: compares the decode index against this line's position.
module decoder_scan_lane #(
    parameter int SEL_W = 3,
    parameter int LANE  = 0
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             thermo,
    output logic             hit
);
    localparam logic [SEL_W-1:0] L = SEL_W'(LANE);

    // Thermometer lights every line at or below the index.
    assign hit = (idx == L) | (thermo & (idx > L));
endmodule

module decoder_scan_seq #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 2**SEL_W,
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    decoder_scan_seq_if.slave io
);
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OUT - 1);

    state_t               state, state_n;
    logic [NUM_OUT-1:0]   out_q, out_n;
    logic [SEL_W-1:0]     idx_q, idx_n;
    logic                 valid_q, valid_n;
    logic                 wrap_q, wrap_n;
    logic                 err_q, err_n;
    logic [DWELL_W-1:0]   cnt_q, cnt_n;

    logic                 thermo_en;
    logic                 accept;
    logic                 sel_ok;
    logic [SEL_W-1:0]     idx_step;
    logic [SEL_W-1:0]     dec_idx;
    logic [NUM_OUT-1:0]   dec_vec;

`ifdef DECODER_THERMO_EN
    assign thermo_en = io.thermo;
`else
    assign thermo_en = 1'b0;
`endif

    // Ready only once already settled in DIRECT: the entry cycle presents
    // out=0 and takes no select.
    assign io.sel_ready = io.enable & ~io.mode & (state == DIRECT);
    assign accept       = io.sel_valid & io.sel_ready;
    assign sel_ok       = {1'b0, io.sel} < (SEL_W+1)'(NUM_OUT);
    assign idx_step     = (idx_q == LAST) ? '0 : idx_q + 1'b1;

    // Mode/enable alone pick the next state.
    always_comb begin
        state_n = IDLE;
        if (io.enable) state_n = io.mode ? SCAN : DIRECT;
    end

    // Single shared decoder: fed by the SCAN step target or the DIRECT sel.
    always_comb begin
        dec_idx = io.sel;
        if (state_n == SCAN) dec_idx = (state == SCAN) ? idx_step : '0;
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
        decoder_scan_lane #(.SEL_W(SEL_W), .LANE(i)) u_lane (
            .idx    (dec_idx),
            .thermo (thermo_en),
            .hit    (dec_vec[i])
        );
    end

    always_comb begin
        out_n   = out_q;
        idx_n   = idx_q;
        valid_n = valid_q;
        cnt_n   = cnt_q;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        case (state_n)
            DIRECT: begin
                if (state != DIRECT) begin
                    out_n   = '0;
                    idx_n   = '0;
                    valid_n = 1'b0;
                    cnt_n   = '0;
                end else if (accept) begin
                    idx_n = io.sel;
                    if (sel_ok) begin
                        out_n   = dec_vec;
                        valid_n = 1'b1;
                    end else begin
                        // Out-of-range select: report it, drive nothing.
                        out_n   = '0;
                        valid_n = 1'b0;
                        err_n   = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (state != SCAN) begin
                    // Always restart from line 0; no wrap pulse on entry.
                    out_n   = dec_vec;
                    idx_n   = '0;
                    valid_n = 1'b1;
                    cnt_n   = io.dwell;
                end else if (cnt_q == '0) begin
                    // dwell is only sampled here, so mid-step changes wait.
                    out_n   = dec_vec;
                    idx_n   = idx_step;
                    valid_n = 1'b1;
                    cnt_n   = io.dwell;
                    wrap_n  = (idx_q == LAST);
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            default: begin
                out_n   = '0;
                idx_n   = '0;
                valid_n = 1'b0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_n;
            idx_q   <= idx_n;
            valid_q <= valid_n;
            wrap_q  <= wrap_n;
            err_q   <= err_n;
            cnt_q   <= cnt_n;
        end
    end

    assign io.out       = out_q;
    assign io.out_idx   = idx_q;
    assign io.out_valid = valid_q;
    assign io.scan_wrap = wrap_q;
    assign io.sel_err   = err_q;
endmodule
